ethpipe_tx_slot: RTL

//  GMII transmit engine of the ethpipe TX path, mirroring the RX path. Reads one frame from
//  the TX slot RAM (a true dual-port RAM: PCIe writes port A, this block reads port B).

---
 rtl/ethpipe_tx_slot.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ethpipe_tx_slot.sv
// rtl/ethpipe_tx_slot.sv - GMII transmit engine sending one frame from the TX slot RAM
// Optional pad/FCS generation is built when ETHPIPE_TX_FCS_EN is defined.

`ifdef ETHPIPE_TX_FCS_EN
module ethpipe_tx_crc32 (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_nxt
);
  logic [31:0] c;

  // Reflected CRC-32 advanced by one byte, bit 0 first
  always_comb begin
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    crc_nxt = c;
  end
endmodule
`endif

module ethpipe_tx_slot #(
  parameter int RD_LAT    = 2,
  parameter int MAX_LEN   = 1518,
  parameter int IFG_BYTES = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic        tx_start,
  input  logic [11:0] tx_frame_len,
  input  logic [31:0] global_counter,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [31:0] tx_timestamp,
  output logic [15:0] tx_frame_cnt,
  output logic [11:0] slot_tx_eth_address,
  input  logic [15:0] slot_tx_eth_q,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_PRE, S_SFD, S_DATA, S_IFG
`ifdef ETHPIPE_TX_FCS_EN
    , S_PAD, S_FCS
`endif
  } state_t;

  // Word k is addressed PF_START+2k cycles after ARM so that it lands in word_r
  // exactly as the last byte of word k-1 leaves the wire: no stall, no FIFO.
  localparam int          PF_START  = 8 - RD_LAT;
  localparam logic        PF_ODD    = (PF_START % 2) != 0;
  localparam logic [11:0] PF_START_W = 12'(PF_START);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);
  localparam logic [11:0] IFG_LAST  = 12'(IFG_BYTES - 1);

  state_t      state, state_nxt;
  logic [11:0] len_r;
  logic [11:0] len_in;
  logic [11:0] bcnt;
  logic [11:0] fcyc;
  logic [11:0] last_word;
  logic [15:0] word_r;
  logic [7:0]  data_byte;
  logic        bcnt_keep;
  logic        addr_step;
  logic        frame_end;

  assign len_in    = (tx_frame_len > MAX_LEN_W) ? MAX_LEN_W : tx_frame_len;
  assign last_word = (len_r - 12'd1) >> 1;
  assign data_byte = bcnt[0] ? word_r[7:0] : word_r[15:8];
  assign frame_end = (state == S_IFG) && (state_nxt == S_IDLE);
  assign addr_step = ((state == S_PRE) || (state == S_SFD) || (state == S_DATA)) &&
                     (fcyc >= PF_START_W) && (fcyc[0] ^ PF_ODD) &&
                     (slot_tx_eth_address < last_word);

`ifdef ETHPIPE_TX_FCS_EN
  logic [31:0] crc_r;
  logic [31:0] crc_nxt;
  logic [31:0] fcs;

  ethpipe_tx_crc32 u_crc (
    .crc     (crc_r),
    .data    (gmii_txd),
    .crc_nxt (crc_nxt)
  );

  assign fcs       = ~crc_r;
  // Pad bytes continue the data byte index so the pad ends at byte 59
  assign bcnt_keep = (state == S_DATA) && (state_nxt == S_PAD);

  // Running CRC over every DATA and PAD byte put on the wire
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst || (state == S_ARM)) begin
      crc_r <= 32'hFFFFFFFF;
    end else if ((state == S_DATA) || (state == S_PAD)) begin
      crc_r <= crc_nxt;
    end
  end
`else
  assign bcnt_keep = 1'b0;
`endif

  // Next-state decode of the transmit sequence
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (tx_start) state_nxt = S_ARM;
      S_ARM:  state_nxt = (len_r == 12'd0) ? S_IDLE : S_PRE;
      S_PRE:  if (bcnt == 12'd6) state_nxt = S_SFD;
      S_SFD:  state_nxt = S_DATA;
      S_DATA: begin
        if (bcnt == len_r - 12'd1) begin
`ifdef ETHPIPE_TX_FCS_EN
          state_nxt = (len_r < 12'd60) ? S_PAD : S_FCS;
`else
          state_nxt = S_IFG;
`endif
        end
      end
`ifdef ETHPIPE_TX_FCS_EN
      S_PAD:  if (bcnt == 12'd59) state_nxt = S_FCS;
      S_FCS:  if (bcnt == 12'd3) state_nxt = S_IFG;
`endif
      S_IFG:  if (bcnt == IFG_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // GMII byte mux and busy flag decoded from the current state
  always_comb begin
    gmii_tx_en = 1'b0;
    gmii_txd   = 8'h00;
    tx_busy    = (state != S_IDLE);
    case (state)
      S_PRE:  begin gmii_tx_en = 1'b1; gmii_txd = 8'h55;      end
      S_SFD:  begin gmii_tx_en = 1'b1; gmii_txd = 8'hD5;      end
      S_DATA: begin gmii_tx_en = 1'b1; gmii_txd = data_byte;  end
`ifdef ETHPIPE_TX_FCS_EN
      S_PAD:  begin gmii_tx_en = 1'b1; gmii_txd = 8'h00;      end
      S_FCS:  begin gmii_tx_en = 1'b1; gmii_txd = fcs[8*bcnt[1:0] +: 8]; end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame counters, slot RAM prefetch and word capture
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      len_r               <= 12'd0;
      bcnt                <= 12'd0;
      fcyc                <= 12'd0;
      word_r              <= 16'h0000;
      slot_tx_eth_address <= 12'd0;
    end else begin
      if (state == S_IDLE) begin
        fcyc                <= 12'd0;
        slot_tx_eth_address <= 12'd0;
        if (tx_start) len_r <= len_in;
      end else begin
        fcyc <= fcyc + 12'd1;
        if (addr_step) slot_tx_eth_address <= slot_tx_eth_address + 12'd1;
      end
      if ((state == S_IDLE) || ((state_nxt != state) && !bcnt_keep)) begin
        bcnt <= 12'd0;
      end else begin
        bcnt <= bcnt + 12'd1;
      end
      if ((state == S_SFD) || ((state == S_DATA) && bcnt[0])) begin
        word_r <= slot_tx_eth_q;
      end
    end
  end

  // Status outputs: SFD timestamp, completion pulse, frame counter
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      tx_done      <= 1'b0;
      tx_timestamp <= 32'd0;
      tx_frame_cnt <= 16'd0;
    end else begin
      tx_done <= frame_end || ((state == S_ARM) && (state_nxt == S_IDLE));
      if ((state == S_PRE) && (state_nxt == S_SFD)) tx_timestamp <= global_counter;
      if (frame_end) tx_frame_cnt <= tx_frame_cnt + 16'd1;
    end
  end

endmodule
